crossy_lane_engine: RTL and testbench
=====================================

Name: crossy_lane_engine

Overview:
- Parametrised N-lane obstacle engine for the VGA Crossy Road game. It replaces the single hard-wired obstacle with NUM_LANES lanes. Each lane scrolls horizontally at its own speed and direction. Every lane scrolls vertically when the player presses the move button.
- Owns per-frame position update, chicken/obstacle collision detection, score counting and a PLAY/HIT/RESTART game state machine.
- Sits between the vga timing block (hpos/vpos/display_on) and the pin-level rgb output. o_score feeds the existing score renderer.

Parameters:
- NUM_LANES, 3, number of obstacle lanes (1..6).
- SCREEN_W, 640, active width in pixels.
- SCREEN_H, 480, active height in pixels.
- LANE_SPACING, 150, reset vertical offset between lanes; NUM_LANES*LANE_SPACING must be <= SCREEN_H.
- LANE_X_OFFSET, 250, reset horizontal offset between lanes, taken mod SCREEN_W.
- OBS_W, 50, obstacle width in pixels.
- OBS_H, 30, obstacle height in pixels.
- CHICKEN_X, 310, chicken left edge.
- CHICKEN_Y, 400, chicken top edge.
- CHICKEN_W, 30, chicken width.
- CHICKEN_H, 40, chicken height.
- HOP_STEP, 40, vertical pixels per accepted hop.
- HIT_FRAMES, 30, frames spent in HIT before restart (1..255).

Ports:
- i_clk, input, 1, pixel clock.
- i_rst_n, input, 1, synchronous active-low reset.
- i_hpos, input, 10, current pixel x from vga.
- i_vpos, input, 10, current pixel y from vga.
- i_display_on, input, 1, active-video flag from vga.
- i_move_btn, input, 1, asynchronous player button, active high.
- o_rgb, output, 3, registered pixel colour {R,G,B}.
- o_score, output, 8, hops since last restart, saturating.
- o_game_over, output, 1, high while in HIT state.

Behaviour:
- Frame tick:
  - single-cycle internal pulse when i_hpos==0 and i_vpos==SCREEN_H (first blanking line).
  - All position, score and state updates occur only on the tick.
- Reset, and the RESTART action:
  - lane i y = i*LANE_SPACING; lane i x = (i*LANE_X_OFFSET) mod SCREEN_W.
  - o_score=0, o_rgb=000, o_game_over=0; state=PLAY.
  - Collision flag and hop-pending flag are cleared.
- Button input:
  - 2-FF synchroniser, then rising-edge detect; an edge sets hop_pending.
  - Any number of edges within one frame give one hop.
  - An edge in the same cycle as the tick is kept pending for the next tick.
  - Edges are ignored (not latched) outside PLAY.
- Horizontal motion (PLAY, each tick):
  - lane i speed = i+1 px/frame.
  - Even lanes move right: x' = x+s, minus SCREEN_W if >= SCREEN_W.
  - Odd lanes move left: x' = x-s, plus SCREEN_W if x < s.
- Vertical motion (PLAY, tick with hop_pending):
  - every lane y' = y+HOP_STEP, minus SCREEN_H if >= SCREEN_H.
  - o_score increments, saturating at 255; hop_pending clears.
  - Horizontal and vertical updates of the same tick apply together.
- Arithmetic: 10-bit positions; comparisons widened to 11 bits so x+OBS_W never wraps. Obstacles are clipped at the right screen edge, not split.
- Hit tests, per pixel, combinational from the current hpos/vpos:
  - lane_hit[i] = x_i <= hpos < x_i+OBS_W && y_i <= vpos < y_i+OBS_H.
  - chick = chicken rectangle; any_hit = OR of lane_hit.
- Collision: coll_flag sets when i_display_on && any_hit && chick. It is sampled and cleared at each tick.
- State machine:
  - PLAY: on a tick with coll_flag=1, go to HIT and load hit_cnt=HIT_FRAMES-1. That tick's motion and hop are suppressed.
  - HIT: positions and score frozen; o_game_over=1. Each tick decrements hit_cnt; a tick at hit_cnt==0 goes to RESTART.
  - RESTART: one cycle; apply the reset values, then go to PLAY.
- Colour priority (registered, 1-cycle latency from hpos/vpos):
  - !display_on gives 000.
  - any_hit && chick gives 011.
  - any_hit gives 100.
  - chick gives 010.
  - otherwise background: 001 in PLAY, 111 in HIT.
- i_rst_n low mid-frame or mid-HIT: the next edge applies the reset values; no partial update survives.

Decomposition:
- Package crossy_pkg holds:
  - screen dimension constants;
  - colour constants (BLACK, BLUE, GREEN, RED, YELLOW, WHITE);
  - state enum {PLAY, HIT, RESTART};
  - 10-bit coordinate typedef.
- Sub-module crossy_lane, generated NUM_LANES times. Parameters: lane index, speed, direction, reset x/y. Inputs: tick, hop, freeze, restart. Outputs: x, y, lane_hit.

Test Plan:
- Reset, defaults: hold i_rst_n=0 for 2 clk → lanes (x,y) = (0,0), (250,150), (500,300); o_score=0; o_rgb=000. After the 1st tick, lane x = 1, 248, 503.
- Hop: one clean press mid-frame → at the next tick, lane y = 40, 190, 340 and o_score=1. Three presses in one frame → only one hop.
- Wraps: with lane0 x=639 the tick gives x=0; with lane1 x=1 (speed 2) it gives x=639. Thirteen hops from reset → lane0 y=520-480=40.
- Collision: force lane2 to x=300 and hop twice so y=380..409 overlaps the chicken → pixel (310,400) outputs 011. Next tick: o_game_over=1, background 111, position frozen for 30 ticks, then reset values with o_score=0.
- Score saturation: 260 hops with collisions suppressed → o_score stays 255.
- Reset mid-HIT: assert i_rst_n=0 at HIT frame 10 → next clk state=PLAY, o_game_over=0, reset positions restored.

Source files
------------

// File: rtl/crossy_lane_engine_pkg.sv
// Shared types and constants for the Crossy Road lane engine: screen size, colours,
// game states and the pixel-in-span helper used by every rectangle hit test.
package crossy_pkg;

   localparam int DEF_SCREEN_W = 640;
   localparam int DEF_SCREEN_H = 480;

   typedef logic [9:0] coord_t;
   typedef logic [2:0] rgb_t;

   localparam rgb_t BLACK  = 3'b000;
   localparam rgb_t BLUE   = 3'b001;
   localparam rgb_t GREEN  = 3'b010;
   localparam rgb_t RED    = 3'b100;
   localparam rgb_t YELLOW = 3'b011;
   localparam rgb_t WHITE  = 3'b111;

   typedef enum logic [1:0] {PLAY, HIT, RESTART} game_state_t;

   // One extra bit so lo+len never wraps; rectangles clip rather than split.
   function automatic logic in_span(coord_t v, coord_t lo, coord_t len);
      return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} < ({1'b0, lo} + {1'b0, len}));
   endfunction

endpackage

// File: rtl/crossy_lane_engine_if.sv
// Pixel-side bundle between the vga timing block, the lane engine and the rgb pins.
interface crossy_lane_engine_if;
   import crossy_pkg::*;

   coord_t i_hpos;
   coord_t i_vpos;
   logic   i_display_on;
   rgb_t   o_rgb;

   modport master (output i_hpos, i_vpos, i_display_on, input o_rgb);
   modport slave  (input i_hpos, i_vpos, i_display_on, output o_rgb);

endinterface

// File: rtl/crossy_lane_engine_lane.sv
// One obstacle lane: scrolls sideways every frame, scrolls down on a hop,
// and reports whether the current pixel lies inside its obstacle.
module crossy_lane
   import crossy_pkg::*;
#(
   parameter int LANE_IDX = 0,
   parameter int SPEED    = LANE_IDX + 1,
   parameter bit DIR_LEFT = (LANE_IDX % 2) == 1,
   parameter int RST_X    = 0,
   parameter int RST_Y    = 0,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H,
   parameter int OBS_W    = 50,
   parameter int OBS_H    = 30,
   parameter int HOP_STEP = 40
) (
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   tick,
   input  logic   hop,
   input  logic   freeze,
   input  logic   restart,
   input  coord_t hpos,
   input  coord_t vpos,
   output coord_t x,
   output coord_t y,
   output logic   lane_hit
);

   localparam logic [10:0] SPD11 = 11'(SPEED);
   localparam logic [10:0] SW11  = 11'(SCREEN_W);
   localparam logic [10:0] SH11  = 11'(SCREEN_H);
   localparam logic [10:0] HOP11 = 11'(HOP_STEP);
   localparam coord_t      SPD10 = 10'(SPEED);
   localparam coord_t      BACK  = 10'(SCREEN_W - SPEED);

   logic [10:0] x_fwd;
   logic [10:0] y_up;
   coord_t      x_nxt;
   coord_t      y_nxt;

   assign x_fwd = {1'b0, x} + SPD11;
   assign y_up  = {1'b0, y} + HOP11;

   always_comb begin
      x_nxt = x;
      y_nxt = y;
      if (DIR_LEFT)
         x_nxt = (x < SPD10) ? x + BACK : x - SPD10;
      else
         x_nxt = (x_fwd >= SW11) ? 10'(x_fwd - SW11) : x_fwd[9:0];
      if (hop)
         y_nxt = (y_up >= SH11) ? 10'(y_up - SH11) : y_up[9:0];
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || restart) begin
         x <= 10'(RST_X);
         y <= 10'(RST_Y);
      end else if (tick && !freeze) begin
         x <= x_nxt;
         y <= y_nxt;
      end
   end

   assign lane_hit = in_span(hpos, x, 10'(OBS_W)) && in_span(vpos, y, 10'(OBS_H));

endmodule

// File: rtl/crossy_lane_engine.sv
// N-lane obstacle engine: frame tick, hop capture, collision, score, colour and game FSM.
// state   | meaning
// PLAY    | lanes scroll each tick; hops and collisions accepted
// HIT     | world frozen, white background, hit_cnt counts down once per tick
// RESTART | single cycle: reload lane positions, clear score and flags
module crossy_lane_engine
   import crossy_pkg::*;
#(
   parameter int NUM_LANES     = 3,
   parameter int SCREEN_W      = DEF_SCREEN_W,
   parameter int SCREEN_H      = DEF_SCREEN_H,
   parameter int LANE_SPACING  = 150,
   parameter int LANE_X_OFFSET = 250,
   parameter int OBS_W         = 50,
   parameter int OBS_H         = 30,
   parameter int CHICKEN_X     = 310,
   parameter int CHICKEN_Y     = 400,
   parameter int CHICKEN_W     = 30,
   parameter int CHICKEN_H     = 40,
   parameter int HOP_STEP      = 40,
   parameter int HIT_FRAMES    = 30
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_move_btn,
   crossy_lane_engine_if.slave  vga,
   output logic [7:0]           o_score,
   output logic                 o_game_over
);

   game_state_t          state, state_nxt;
   logic [7:0]           hit_cnt, hit_cnt_nxt;
   logic                 tick, restart, freeze;
   logic                 coll_flag, hop_pending;
   logic [2:0]           btn_sync;
   logic                 btn_edge, chick, any_hit;
   logic [NUM_LANES-1:0] lane_hit;
   coord_t               lane_x [NUM_LANES];
   coord_t               lane_y [NUM_LANES];
   rgb_t                 rgb_nxt;

   assign tick     = (vga.i_hpos == 10'd0) && (vga.i_vpos == 10'(SCREEN_H));
   assign btn_edge = btn_sync[1] & ~btn_sync[2];
   assign chick    = in_span(vga.i_hpos, 10'(CHICKEN_X), 10'(CHICKEN_W)) &&
                     in_span(vga.i_vpos, 10'(CHICKEN_Y), 10'(CHICKEN_H));
   assign any_hit  = |lane_hit;
   // A colliding tick freezes motion and hop so HIT shows the crash position.
   assign freeze   = (state != PLAY) || coll_flag;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      crossy_lane #(
         .LANE_IDX (i),
         .RST_X    ((i * LANE_X_OFFSET) % SCREEN_W),
         .RST_Y    (i * LANE_SPACING),
         .SCREEN_W (SCREEN_W),
         .SCREEN_H (SCREEN_H),
         .OBS_W    (OBS_W),
         .OBS_H    (OBS_H),
         .HOP_STEP (HOP_STEP)
      ) u_lane (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .tick     (tick),
         .hop      (hop_pending),
         .freeze   (freeze),
         .restart  (restart),
         .hpos     (vga.i_hpos),
         .vpos     (vga.i_vpos),
         .x        (lane_x[i]),
         .y        (lane_y[i]),
         .lane_hit (lane_hit[i])
      );
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) btn_sync <= '0;
      else          btn_sync <= {btn_sync[1:0], i_move_btn};
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || restart) begin
         hop_pending <= 1'b0;
         coll_flag   <= 1'b0;
         o_score     <= 8'd0;
      end else begin
         if (tick)
            coll_flag <= 1'b0;
         else if (vga.i_display_on && any_hit && chick)
            coll_flag <= 1'b1;
         // An edge coinciding with the tick is carried into the next frame.
         if (state == PLAY) begin
            if (tick)          hop_pending <= btn_edge;
            else if (btn_edge) hop_pending <= 1'b1;
         end
         if (tick && !freeze && hop_pending && (o_score != 8'hFF))
            o_score <= o_score + 8'd1;
      end
   end

   always_comb begin
      rgb_nxt = (state == HIT) ? WHITE : BLUE;
      if (!vga.i_display_on)     rgb_nxt = BLACK;
      else if (any_hit && chick) rgb_nxt = YELLOW;
      else if (any_hit)          rgb_nxt = RED;
      else if (chick)            rgb_nxt = GREEN;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || restart) vga.o_rgb <= BLACK;
      else                     vga.o_rgb <= rgb_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state   <= PLAY;
         hit_cnt <= 8'd0;
      end else begin
         state   <= state_nxt;
         hit_cnt <= hit_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      hit_cnt_nxt = hit_cnt;
      restart     = 1'b0;
      o_game_over = 1'b0;
      case (state)
         PLAY: begin
            if (tick && coll_flag) begin
               state_nxt   = HIT;
               hit_cnt_nxt = 8'(HIT_FRAMES - 1);
            end
         end
         HIT: begin
            o_game_over = 1'b1;
            if (tick) begin
               if (hit_cnt == 8'd0) state_nxt   = RESTART;
               else                 hit_cnt_nxt = hit_cnt - 8'd1;
            end
         end
         RESTART: begin
            restart   = 1'b1;
            state_nxt = PLAY;
         end
         default: state_nxt = PLAY;
      endcase
   end

endmodule

// File: tb/tb_crossy_lane_engine.sv
// Directed bench for crossy_lane_engine: frame ticks and pixels are driven directly,
// expected lane positions, score and colours are hand-computed constants.
module tb_crossy_lane_engine;
   import crossy_pkg::*;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn   = 1'b0;
   logic [7:0] score;
   logic       game_over;
   int         n_tests = 0;
   int         n_fail  = 0;

   crossy_lane_engine_if vga ();

   crossy_lane_engine dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_move_btn  (btn),
      .vga         (vga),
      .o_score     (score),
      .o_game_over (game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_lanes(input string tag, input int x0, x1, x2, y0, y1, y2);
      chk({tag, "_x0"}, 32'(dut.lane_x[0]), x0);
      chk({tag, "_x1"}, 32'(dut.lane_x[1]), x1);
      chk({tag, "_x2"}, 32'(dut.lane_x[2]), x2);
      chk({tag, "_y0"}, 32'(dut.lane_y[0]), y0);
      chk({tag, "_y1"}, 32'(dut.lane_y[1]), y1);
      chk({tag, "_y2"}, 32'(dut.lane_y[2]), y2);
   endtask

   task automatic idle_bus();
      vga.i_hpos       = 10'd700;
      vga.i_vpos       = 10'd500;
      vga.i_display_on = 1'b0;
   endtask

   task automatic frame_tick();
      @(negedge clk);
      vga.i_hpos       = 10'd0;
      vga.i_vpos       = 10'd480;
      vga.i_display_on = 1'b0;
      @(negedge clk);
      idle_bus();
   endtask

   task automatic press();
      @(negedge clk);
      btn = 1'b1;
      repeat (3) @(negedge clk);
      btn = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic probe(input int h, input int v, input logic on, input rgb_t exp, input string tag);
      @(negedge clk);
      vga.i_hpos       = 10'(h);
      vga.i_vpos       = 10'(v);
      vga.i_display_on = on;
      @(negedge clk);
      chk(tag, 32'(vga.o_rgb), 32'(exp));
      idle_bus();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_bus();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk_lanes("rst", 0, 250, 500, 0, 150, 300);
      chk("rst_score", 32'(score), 0);
      chk("rst_rgb", 32'(vga.o_rgb), 0);
      chk("rst_game_over", 32'(game_over), 0);

      frame_tick();                                         // t=1
      chk_lanes("tick1", 1, 248, 503, 0, 150, 300);

      press();
      frame_tick();                                         // t=2
      chk_lanes("hop1", 2, 246, 506, 40, 190, 340);
      chk("hop1_score", 32'(score), 1);

      press(); press(); press();
      frame_tick();                                         // t=3
      chk_lanes("hop3", 3, 244, 509, 80, 230, 380);
      chk("hop3_score", 32'(score), 2);

      probe(5, 90, 1'b1, RED, "px_lane0");
      probe(320, 420, 1'b1, GREEN, "px_chick");
      probe(600, 10, 1'b1, BLUE, "px_bg_play");
      probe(5, 90, 1'b0, BLACK, "px_blank");

      // Edge reaches the edge detector exactly on the tick cycle.
      @(negedge clk);
      btn = 1'b1;
      @(negedge clk);
      @(negedge clk);
      vga.i_hpos = 10'd0;
      vga.i_vpos = 10'd480;
      @(negedge clk);                                       // t=4
      idle_bus();
      btn = 1'b0;
      chk_lanes("edge_tick", 4, 242, 512, 80, 230, 380);
      chk("edge_tick_score", 32'(score), 2);
      repeat (3) @(negedge clk);
      frame_tick();                                         // t=5
      chk_lanes("edge_next", 5, 240, 515, 120, 270, 420);
      chk("edge_next_score", 32'(score), 3);

      repeat (120) frame_tick();                            // t=125
      chk("l1_at_zero", 32'(dut.lane_x[1]), 0);
      frame_tick();                                         // t=126
      chk("l1_wrap", 32'(dut.lane_x[1]), 638);
      chk("l2_t126", 32'(dut.lane_x[2]), 238);

      repeat (14) frame_tick();                             // t=140
      chk("l2_t140", 32'(dut.lane_x[2]), 280);
      probe(320, 425, 1'b1, YELLOW, "px_collide");
      frame_tick();                                         // enters HIT
      chk("hit_game_over", 32'(game_over), 1);
      chk_lanes("hit_frozen", 140, 610, 280, 120, 270, 420);
      chk("hit_score", 32'(score), 3);
      probe(600, 10, 1'b1, WHITE, "px_bg_hit");

      press();
      repeat (29) frame_tick();
      chk("hit_still", 32'(game_over), 1);
      chk("hit_hold_x2", 32'(dut.lane_x[2]), 280);
      frame_tick();                                         // 30th HIT tick
      chk("restart_state", 32'(dut.state), 32'(RESTART));
      @(negedge clk);
      chk("play_state", 32'(dut.state), 32'(PLAY));
      chk("restart_game_over", 32'(game_over), 0);
      chk("restart_score", 32'(score), 0);
      chk_lanes("restart", 0, 250, 500, 0, 150, 300);

      frame_tick();                                         // t=1, press in HIT ignored
      chk_lanes("post_restart", 1, 248, 503, 0, 150, 300);

      repeat (13) begin press(); frame_tick(); end          // t=14
      chk_lanes("hop13", 14, 222, 542, 40, 190, 340);
      chk("hop13_score", 32'(score), 13);

      repeat (625) begin press(); frame_tick(); end         // t=639, 638 hops
      chk("l0_639", 32'(dut.lane_x[0]), 639);
      chk("score_sat", 32'(score), 255);
      press();
      frame_tick();                                         // t=640
      chk_lanes("l0_wrap", 0, 250, 500, 120, 270, 420);
      chk("score_sat2", 32'(score), 255);

      repeat (140) frame_tick();                            // t=780
      chk("l2_t780", 32'(dut.lane_x[2]), 280);
      probe(320, 425, 1'b1, YELLOW, "px_collide2");
      frame_tick();
      chk("hit2_game_over", 32'(game_over), 1);
      repeat (9) frame_tick();
      chk("hit2_score", 32'(score), 255);
      chk("hit2_x0", 32'(dut.lane_x[0]), 140);

      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rsthit_state", 32'(dut.state), 32'(PLAY));
      chk("rsthit_game_over", 32'(game_over), 0);
      chk("rsthit_score", 32'(score), 0);
      chk_lanes("rsthit", 0, 250, 500, 0, 150, 300);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
